text_console_ctrl: RTL

Character-stream controller that sequences writes into the 80x60 text-mode character RAM of the video block. It accepts a byte stream over a valid/ready handshake, and maintains a cursor. It executes printable writes, CR/LF/BS, clear-screen and hardware scroll-up by driving the video block's single-cycle bus as the master. It sits between a CPU/UART source and the video slave port, relieving software of cursor and scroll bookkeeping.

---
 rtl/text_console_ctrl.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/text_console_ctrl.sv
// Text console controller: turns a byte stream into cursor-tracked writes,
// clears and hardware scrolls on the 80x60 character RAM of the video block.
//
// Ports:
//   clk_25mhz, rst_i (async, active low)
//   ch_valid_i/ch_data_i/ch_ready_o : byte stream in (accepted only in IDLE)
//   cls_i                           : clear-screen request, wins over a byte
//   busy_o, cur_col_o, cur_row_o    : status and cursor
//   m_adr_o/m_dat_o/m_sel_o/m_we_o/m_stb_o/m_ack_i/m_dat_i : bus master
module text_console_ctrl #(
    parameter int unsigned COLS  = 80,
    parameter int unsigned ROWS  = 60,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk_25mhz,
    input  logic        rst_i,
    input  logic        ch_valid_i,
    input  logic [7:0]  ch_data_i,
    output logic        ch_ready_o,
    input  logic        cls_i,
    output logic        busy_o,
    output logic [6:0]  cur_col_o,
    output logic [5:0]  cur_row_o,
    output logic [12:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i
);

    localparam logic [12:0] COLS13   = 13'(COLS);
    localparam logic [12:0] LAST_ADR = 13'(COLS * ROWS - 1);
    localparam logic [12:0] LAST_SCR = 13'(COLS * (ROWS - 1) - 1);
    localparam logic [12:0] FILL_ADR = 13'(COLS * (ROWS - 1));
    localparam logic [6:0]  COL_MAX  = 7'(COLS - 1);
    localparam logic [5:0]  ROW_MAX  = 6'(ROWS - 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUT,
        S_SCR_RD,
        S_SCR_WAIT,
        S_SCR_WR,
        S_FILL,
        S_CLR
    } state_e;

    function automatic logic [3:0] lane_sel(input logic [12:0] a);
        lane_sel = 4'b0001 << a[1:0];
    endfunction

    function automatic logic [12:0] cell_adr(input logic [6:0] c,
                                             input logic [5:0] r);
        cell_adr = 13'(r) * COLS13 + 13'(c);
    endfunction

    state_e      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    // Cursor to commit when the final write of the current operation acks
    logic [6:0]  ncol_q, ncol_d;
    logic [5:0]  nrow_q, nrow_d;
    // A PUT that wrapped past the last row continues into a scroll
    logic        scr_q, scr_d;
    logic [12:0] cnt_q, cnt_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [12:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;

    logic [7:0]  rd_byte;
    logic [12:0] put_adr;
    logic [12:0] bs_adr;
    logic [12:0] nxt_adr;
    logic [12:0] cnt_inc;
    logic [12:0] nxt_src;

    always_ff @(posedge clk_25mhz or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            ncol_q  <= '0;
            nrow_q  <= '0;
            scr_q   <= 1'b0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ncol_q  <= ncol_d;
            nrow_q  <= nrow_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        ncol_d  = ncol_q;
        nrow_d  = nrow_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;

        // adr_q still holds the read source while waiting for the data
        rd_byte = m_dat_i[{adr_q[1:0], 3'b000} +: 8];
        put_adr = cell_adr(col_q, row_q);
        bs_adr  = cell_adr(col_q - 7'd1, row_q);
        nxt_adr = adr_q + 13'd1;
        cnt_inc = cnt_q + 13'd1;
        nxt_src = cnt_inc + COLS13;

        unique case (state_q)
            S_IDLE: begin
                if (cls_i || (ch_valid_i && ch_data_i == CH_FF)) begin
                    state_d = S_CLR;
                    ncol_d  = '0;
                    nrow_d  = '0;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = '0;
                    sel_d   = 4'b0001;
                    dat_d   = {4{BLANK}};
                end else if (ch_valid_i) begin
                    case (ch_data_i)
                        CH_CR: col_d = '0;
                        CH_LF: begin
                            if (row_q != ROW_MAX) begin
                                col_d = '0;
                                row_d = row_q + 6'd1;
                            end else begin
                                state_d = S_SCR_RD;
                                ncol_d  = '0;
                                nrow_d  = row_q;
                                cnt_d   = '0;
                                stb_d   = 1'b1;
                                we_d    = 1'b0;
                                adr_d   = COLS13;
                                sel_d   = lane_sel(COLS13);
                            end
                        end
                        CH_BS: begin
                            if (col_q != '0) begin
                                state_d = S_PUT;
                                ncol_d  = col_q - 7'd1;
                                nrow_d  = row_q;
                                scr_d   = 1'b0;
                                stb_d   = 1'b1;
                                we_d    = 1'b1;
                                adr_d   = bs_adr;
                                sel_d   = lane_sel(bs_adr);
                                dat_d   = {4{BLANK}};
                            end
                        end
                        default: begin
                            state_d = S_PUT;
                            stb_d   = 1'b1;
                            we_d    = 1'b1;
                            adr_d   = put_adr;
                            sel_d   = lane_sel(put_adr);
                            dat_d   = {4{ch_data_i}};
                            scr_d   = 1'b0;
                            nrow_d  = row_q;
                            if (col_q == COL_MAX) begin
                                ncol_d = '0;
                                if (row_q == ROW_MAX) begin
                                    scr_d = 1'b1;
                                end else begin
                                    nrow_d = row_q + 6'd1;
                                end
                            end else begin
                                ncol_d = col_q + 7'd1;
                            end
                        end
                    endcase
                end
            end
            S_PUT: begin
                if (m_ack_i) begin
                    if (scr_q) begin
                        state_d = S_SCR_RD;
                        cnt_d   = '0;
                        we_d    = 1'b0;
                        adr_d   = COLS13;
                        sel_d   = lane_sel(COLS13);
                    end else begin
                        state_d = S_IDLE;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                        col_d   = ncol_q;
                        row_d   = nrow_q;
                    end
                end
            end
            S_SCR_RD: begin
                if (m_ack_i) begin
                    state_d = S_SCR_WAIT;
                    stb_d   = 1'b0;
                end
            end
            S_SCR_WAIT: begin
                state_d = S_SCR_WR;
                stb_d   = 1'b1;
                we_d    = 1'b1;
                adr_d   = cnt_q;
                sel_d   = lane_sel(cnt_q);
                dat_d   = {4{rd_byte}};
            end
            S_SCR_WR: begin
                if (m_ack_i) begin
                    if (cnt_q == LAST_SCR) begin
                        state_d = S_FILL;
                        adr_d   = FILL_ADR;
                        sel_d   = lane_sel(FILL_ADR);
                        dat_d   = {4{BLANK}};
                    end else begin
                        state_d = S_SCR_RD;
                        cnt_d   = cnt_inc;
                        we_d    = 1'b0;
                        adr_d   = nxt_src;
                        sel_d   = lane_sel(nxt_src);
                    end
                end
            end
            S_FILL, S_CLR: begin
                if (m_ack_i) begin
                    if (adr_q == LAST_ADR) begin
                        state_d = S_IDLE;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                        col_d   = ncol_q;
                        row_d   = nrow_q;
                    end else begin
                        adr_d = nxt_adr;
                        sel_d = lane_sel(nxt_adr);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ch_ready_o = (state_q == S_IDLE) && !cls_i;
    assign busy_o     = (state_q != S_IDLE);
    assign cur_col_o  = col_q;
    assign cur_row_o  = row_q;
    assign m_adr_o    = adr_q;
    assign m_dat_o    = dat_q;
    assign m_sel_o    = sel_q;
    assign m_we_o     = we_q;
    assign m_stb_o    = stb_q;

endmodule
